key_bit_sequencer: RTL

- Reads the scalar key for the GF(2^233) point multiplier and feeds it bit by bit, MSB first, to the ladder controller.
- Handles the consumer side of the key-iteration interface: latches the key, optionally skips leading zeros, and presents one bit per ready/valid handshake.
- Signals the end of the scalar.
- Replaces a free-running down-count with flow-controlled, index-tagged bit delivery.

---
 rtl/ecp_pkg.sv | 15 +
 rtl/key_idx_counter.sv | 38 +++
 rtl/key_bit_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ecp_pkg.sv
// Shared defaults and state encoding for the GF(2^233) point-multiplier key path.
// Pure declarations: no logic, no latency.
package ecp_pkg;

    localparam int KEY_WIDTH_DEF = 32;
    localparam int IDX_W_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/key_idx_counter.sv
// Loadable down-counter for the key bit index; load wins over enable, one-cycle update.
// Holds at zero instead of wrapping, so callers never see an underflow.
module key_idx_counter #(
    parameter int IDX_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [IDX_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             zero_o
);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (load_i) begin
            idx_d = load_val_i;
        end else if (en_i && (idx_q != '0)) begin
            idx_d = idx_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign zero_o = (idx_q == '0);

endmodule

// File: rtl/key_bit_sequencer.sv
// Latches a scalar and delivers it MSB-first, one index-tagged bit per valid/ready handshake.
// First bit 2+z cycles after start (z skipped leading zeros); outputs hold while bit_ready_i is low.
module key_bit_sequencer
    import ecp_pkg::*;
#(
    parameter int KEY_WIDTH    = KEY_WIDTH_DEF,
    parameter int IDX_W        = IDX_W_DEF,
    parameter bit SKIP_LEADING = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [KEY_WIDTH-1:0] key_i,
    output logic                 bit_valid_o,
    input  logic                 bit_ready_i,
    output logic                 bit_out_o,
    output logic [IDX_W-1:0]     bit_idx_o,
    output logic                 first_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 zero_key_o
);

    localparam int               KSEL_W  = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(KEY_WIDTH - 1);

    seq_state_e           state_q;
    logic [KEY_WIDTH-1:0] key_q;
    logic                 bit_valid_q;
    logic                 bit_out_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic                 first_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 zero_key_q;

    logic [IDX_W-1:0]     idx;
    logic                 idx_zero;
    logic                 cnt_load;
    logic                 cnt_en;
    logic                 hs;
    logic [KSEL_W-1:0]    sel_cur;
    logic [KSEL_W-1:0]    sel_nxt;

    assign hs      = bit_valid_q & bit_ready_i;
    assign sel_cur = idx[KSEL_W-1:0];
    assign sel_nxt = KSEL_W'(idx - IDX_W'(1));

    // The counter tracks the bit under inspection; the FSM only steers it.
    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            IDLE:    cnt_load = start_i;
            SCAN:    cnt_en   = ~key_q[sel_cur];
            ISSUE:   cnt_en   = hs;
            default: ;
        endcase
    end

    key_idx_counter #(
        .IDX_W (IDX_W)
    ) u_idx (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (TOP_IDX),
        .en_i       (cnt_en),
        .idx_o      (idx),
        .zero_o     (idx_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            key_q       <= '0;
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_idx_q   <= '0;
            first_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zero_key_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        key_q      <= key_i;
                        zero_key_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (SKIP_LEADING) begin
                            state_q <= SCAN;
                        end else begin
                            state_q     <= ISSUE;
                            bit_valid_q <= 1'b1;
                            bit_out_q   <= key_i[KEY_WIDTH-1];
                            bit_idx_q   <= TOP_IDX;
                            first_q     <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (key_q[sel_cur]) begin
                        state_q     <= ISSUE;
                        bit_valid_q <= 1'b1;
                        bit_out_q   <= 1'b1;
                        bit_idx_q   <= idx;
                        first_q     <= 1'b1;
                    end else if (idx_zero) begin
                        state_q    <= DONE;
                        zero_key_q <= 1'b1;
                        done_q     <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        first_q <= 1'b0;
                        if (idx_zero) begin
                            state_q     <= DONE;
                            bit_valid_q <= 1'b0;
                            bit_out_q   <= 1'b0;
                            bit_idx_q   <= '0;
                            done_q      <= 1'b1;
                        end else begin
                            bit_out_q <= key_q[sel_nxt];
                            bit_idx_q <= idx - IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bit_valid_o = bit_valid_q;
    assign bit_out_o   = bit_out_q;
    assign bit_idx_o   = bit_idx_q;
    assign first_o     = first_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign zero_key_o  = zero_key_q;

endmodule
